ahb_slave_sram: RTL and testbench

AHB-Lite responder (slave) that fronts a single-port synchronous SRAM. It is the target-side counterpart of the master path: it accepts address phases and drives HREADYOUT/HRESP/HRDATA, and inserts wait states instead of consuming them. It converts AHB pipelined transfers into SRAM enable/write/byte-enable strobes. Alignment, size and range errors return the standard two-cycle ERROR response.

---
 rtl/ahb_slave_pkg.sv | 32 +++
 rtl/ahb_slave_addr_chk.sv | 43 ++++
 rtl/ahb_slave_sram.sv | 134 +++++++++++++
 tb/tb_ahb_slave_sram.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_slave_pkg.sv
// Shared types for the AHB-Lite SRAM responder.
// Transfer encodings, response codes and FSM states.
package ahb_slave_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_REG   = 3'd3,
        ST_RD_DATA  = 3'd4,
        ST_ERR1     = 3'd5,
        ST_ERR2     = 3'd6
    } state_t;

endpackage

// File: rtl/ahb_slave_addr_chk.sv
// Address-phase decode: byte lanes, SRAM word index and error flag.
// Errors cover oversize transfers, misalignment and out-of-range words.
module ahb_slave_addr_chk
    import ahb_slave_pkg::*;
#(
    parameter int DATA_WDT  = 32,
    parameter int ADDR_WDT  = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic [ADDR_WDT-1:0]          i_haddr,
    input  logic [2:0]                   i_hsize,
    output logic [DATA_WDT/8-1:0]        o_be,
    output logic [$clog2(MEM_DEPTH)-1:0] o_idx,
    output logic                         o_err
);

    localparam int BW = DATA_WDT / 8;
    localparam int BL = $clog2(BW);
    localparam int AW = $clog2(MEM_DEPTH);

    logic [7:0]          base;
    logic [7:0]          amask;
    logic [ADDR_WDT-1:0] widx;

    // Lane mask for the size, placed at the byte offset within the bus word.
    always_comb begin
        base = 8'hFF;
        case (i_hsize)
            HSIZE_BYTE: base = 8'h01;
            HSIZE_HALF: base = 8'h03;
            HSIZE_WORD: base = 8'h0F;
            default:    base = 8'hFF;
        endcase
        amask = (8'd1 << i_hsize) - 8'd1;
        widx  = i_haddr >> BL;
        o_idx = widx[AW-1:0];
        o_be  = BW'(base) << i_haddr[BL-1:0];
        o_err = (i_hsize > 3'(BL))
              | (|(i_haddr[7:0] & amask))
              | (widx >= ADDR_WDT'(MEM_DEPTH));
    end

endmodule

// File: rtl/ahb_slave_sram.sv
// AHB-Lite responder in front of a single-port synchronous SRAM.
// Define AHB_SLAVE_SRAM_RDATA_REG_EN to register SRAM read data (2 read waits).
module ahb_slave_sram
    import ahb_slave_pkg::*;
#(
    parameter int DATA_WDT  = 32,
    parameter int ADDR_WDT  = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                         i_clk,
    input  logic                         i_resetn,
    input  logic                         i_hsel,
    input  logic [ADDR_WDT-1:0]          i_haddr,
    input  logic [1:0]                   i_htrans,
    input  logic                         i_hwrite,
    input  logic [2:0]                   i_hsize,
    input  logic [DATA_WDT-1:0]          i_hwdata,
    input  logic                         i_hready,
    output logic                         o_hreadyout,
    output logic                         o_hresp,
    output logic [DATA_WDT-1:0]          o_hrdata,
    output logic                         o_mem_en,
    output logic                         o_mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0] o_mem_addr,
    output logic [DATA_WDT/8-1:0]        o_mem_be,
    output logic [DATA_WDT-1:0]          o_mem_wdata,
    input  logic [DATA_WDT-1:0]          i_mem_rdata
);

    localparam int BW = DATA_WDT / 8;
    localparam int AW = $clog2(MEM_DEPTH);

    state_t              state_q, state_d, acc_st;
    logic                accept;
    logic                chk_err;
    logic [BW-1:0]       chk_be;
    logic [AW-1:0]       chk_idx;
    logic                hreadyout_q, hresp_q;
    logic                mem_en_q, mem_we_q;
    logic [AW-1:0]       mem_addr_q;
    logic [BW-1:0]       mem_be_q;
    logic [DATA_WDT-1:0] hrdata_q;
    logic                access_d;

    ahb_slave_addr_chk #(
        .DATA_WDT  (DATA_WDT),
        .ADDR_WDT  (ADDR_WDT),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_chk (
        .i_haddr (i_haddr),
        .i_hsize (i_hsize),
        .o_be    (chk_be),
        .o_idx   (chk_idx),
        .o_err   (chk_err)
    );

    assign accept = i_hsel & i_hready
                  & ((i_htrans == HTRANS_NONSEQ) | (i_htrans == HTRANS_SEQ));

    // Next state when a data phase ends: follow the new address phase, if any.
    always_comb begin
        acc_st = ST_IDLE;
        if (accept) begin
            if (chk_err)       acc_st = ST_ERR1;
            else if (i_hwrite) acc_st = ST_WRITE;
            else               acc_st = ST_RD_ISSUE;
        end
    end

    // Transition table; stalled states ignore the bus entirely.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE,
            ST_WRITE,
            ST_RD_DATA,
            ST_ERR2:     state_d = acc_st;
`ifdef AHB_SLAVE_SRAM_RDATA_REG_EN
            ST_RD_ISSUE: state_d = ST_RD_REG;
`else
            ST_RD_ISSUE: state_d = ST_RD_DATA;
`endif
            ST_RD_REG:   state_d = ST_RD_DATA;
            ST_ERR1:     state_d = ST_ERR2;
            default:     state_d = ST_IDLE;
        endcase
        access_d = (state_d == ST_WRITE) | (state_d == ST_RD_ISSUE);
    end

    // FSM with bus and SRAM strobes registered from the next state.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= !((state_d == ST_RD_ISSUE) |
                             (state_d == ST_RD_REG) |
                             (state_d == ST_ERR1));
            hresp_q     <= ((state_d == ST_ERR1) | (state_d == ST_ERR2))
                         ? HRESP_ERROR : HRESP_OKAY;
            mem_en_q    <= access_d;
            mem_we_q    <= (state_d == ST_WRITE);
            mem_addr_q  <= access_d ? chk_idx : '0;
            mem_be_q    <= access_d ? chk_be : '0;
`ifdef AHB_SLAVE_SRAM_RDATA_REG_EN
            if (state_q == ST_RD_REG) hrdata_q <= i_mem_rdata;
`else
            if (state_q == ST_RD_DATA) hrdata_q <= i_mem_rdata;
`endif
        end
    end

`ifdef AHB_SLAVE_SRAM_RDATA_REG_EN
    assign o_hrdata = hrdata_q;
`else
    assign o_hrdata = (state_q == ST_RD_DATA) ? i_mem_rdata : hrdata_q;
`endif

    assign o_hreadyout = hreadyout_q;
    assign o_hresp     = hresp_q;
    assign o_mem_en    = mem_en_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_be    = mem_be_q;
    assign o_mem_wdata = mem_we_q ? i_hwdata : '0;

endmodule

// File: tb/tb_ahb_slave_sram.sv
// Scoreboard bench for ahb_slave_sram with a byte-level memory model.
// Honours AHB_SLAVE_SRAM_RDATA_REG_EN for the expected read wait count.
module tb_ahb_slave_sram;

    localparam int DEPTH = 1024;
`ifdef AHB_SLAVE_SRAM_RDATA_REG_EN
    localparam int RD_WAITS = 2;
`else
    localparam int RD_WAITS = 1;
`endif
    localparam logic [1:0] K_WR  = 2'd0;
    localparam logic [1:0] K_RD  = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [31:0] hwdata = '0;
    logic        hready;
    logic        hreadyout, hresp;
    logic [31:0] hrdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        hready_ovr = 1'b0;
    logic        hready_val = 1'b1;
    logic        mem_clear = 1'b1;
    logic        mon_en = 1'b1;

    int checks = 0;
    int errors = 0;
    int waits = 0;
    logic [31:0] pend_wdata = '0;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
        logic [9:0]  idx;
        logic [3:0]  be;
    } exp_t;

    exp_t exp_q[$];
    bit [7:0] ref_mem [DEPTH*4];
    logic [31:0] sram [DEPTH];

    assign hready = hready_ovr ? hready_val : hreadyout;

    always #5 clk = ~clk;

    ahb_slave_sram dut (
        .i_clk       (clk),
        .i_resetn    (resetn),
        .i_hsel      (hsel),
        .i_haddr     (haddr),
        .i_htrans    (htrans),
        .i_hwrite    (hwrite),
        .i_hsize     (hsize),
        .i_hwdata    (hwdata),
        .i_hready    (hready),
        .o_hreadyout (hreadyout),
        .o_hresp     (hresp),
        .o_hrdata    (hrdata),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_be    (mem_be),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    // Synchronous SRAM the responder drives.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= '0;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic int req_waits(input logic [1:0] k);
        if (k == K_RD) return RD_WAITS;
        if (k == K_ERR) return 1;
        return 0;
    endfunction

    // Reference: byte-addressed memory, AHB size/alignment/range rules.
    task automatic model(input logic wr, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd);
        exp_t e;
        int nb, off, idx;
        e = '0;
        nb = 1 << sz;
        if (sz > 3'd2 || (a % nb) != 0 || (a / 4) >= DEPTH) begin
            e.kind = K_ERR;
        end else begin
            off = int'(a % 4);
            idx = int'(a / 4);
            e.idx = 10'(idx);
            for (int b = 0; b < 4; b++) e.be[b] = (b >= off) && (b < off + nb);
            if (wr) begin
                e.kind = K_WR;
                e.data = wd;
                for (int b = 0; b < 4; b++)
                    if (e.be[b]) ref_mem[idx*4+b] = wd[b*8 +: 8];
            end else begin
                e.kind = K_RD;
                for (int b = 0; b < 4; b++) e.data[b*8 +: 8] = ref_mem[idx*4+b];
            end
        end
        exp_q.push_back(e);
    endtask

    // One address phase as a master; waits for HREADY before it counts.
    task automatic cycle(input logic sel, input logic [1:0] tr, input logic wr,
                         input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd);
        int n;
        @(negedge clk);
        hsel = sel; htrans = tr; hwrite = wr; haddr = a; hsize = sz;
        hwdata = pend_wdata;
        n = 0;
        while (hready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("hready_timeout", 32'(n), 32'(0));
        @(posedge clk);
        if (sel && tr[1]) begin
            model(wr, a, sz, wd);
            if (wr) pend_wdata = wd;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 1'b0, 32'h0, 3'd0, 32'h0);
    endtask

    // Monitor: pops one expectation per completed data phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && exp_q.size() != 0) begin
                e = exp_q[0];
                if (e.kind == K_ERR) chk("err_no_mem", 32'(mem_en), 32'(0));
                if (hreadyout === 1'b1) begin
                    chk("waits", 32'(waits), 32'(req_waits(e.kind)));
                    chk("hresp", 32'(hresp), 32'(e.kind == K_ERR));
                    if (e.kind == K_RD) chk("rdata", hrdata, e.data);
                    if (e.kind == K_WR) begin
                        chk("wr_en_we", 32'({mem_en, mem_we}), 32'(2'b11));
                        chk("wr_addr", 32'(mem_addr), 32'(e.idx));
                        chk("wr_be", 32'(mem_be), 32'(e.be));
                        chk("wr_data", mem_wdata, e.data);
                    end
                    void'(exp_q.pop_front());
                    waits = 0;
                end else begin
                    if (waits == 0 && e.kind == K_RD) begin
                        chk("rd_en_we", 32'({mem_en, mem_we}), 32'(2'b10));
                        chk("rd_addr", 32'(mem_addr), 32'(e.idx));
                    end
                    if (e.kind == K_ERR) chk("err1_hresp", 32'(hresp), 32'(1));
                    waits++;
                    if (waits > 20) begin
                        chk("dphase_timeout", 32'(waits), 32'(req_waits(e.kind)));
                        void'(exp_q.pop_front());
                        waits = 0;
                    end
                end
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 32'(exp_q.size()), 32'(0));
        idle(2);
    endtask

    initial begin
        logic [2:0]  sz;
        logic [31:0] a;
        int          r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_hreadyout", 32'(hreadyout), 32'(1));
        chk("rst_hresp", 32'(hresp), 32'(0));
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_mem", 32'({mem_en, mem_we, mem_addr, mem_be}), 32'(0));
        chk("rst_wdata", mem_wdata, 32'h0);
        resetn = 1'b1;
        mem_clear = 1'b0;

        cycle(1'b1, 2'd2, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        cycle(1'b1, 2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
        cycle(1'b1, 2'd2, 1'b1, 32'h13, 3'd0, 32'hAA000000);
        cycle(1'b1, 2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
        cycle(1'b1, 2'd2, 1'b0, 32'h01, 3'd1, 32'h0);
        cycle(1'b1, 2'd2, 1'b1, 32'h1000, 3'd2, 32'h12345678);
        cycle(1'b1, 2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
        drain();

        @(negedge clk);
        hready_ovr = 1'b1; hready_val = 1'b0;
        hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
        hwdata = 32'hCAFEF00D;
        @(negedge clk);
        #1;
        chk("nrdy_mem_en", 32'(mem_en), 32'(0));
        chk("nrdy_hreadyout", 32'(hreadyout), 32'(1));
        hready_ovr = 1'b0; htrans = 2'd1;
        @(negedge clk);
        #1;
        chk("busy_mem_en", 32'(mem_en), 32'(0));
        chk("busy_hreadyout", 32'(hreadyout), 32'(1));
        hsel = 1'b0; htrans = 2'd0;
        cycle(1'b1, 2'd2, 1'b0, 32'h20, 3'd2, 32'h0);
        drain();

        for (int t = 0; t < 400; t++) begin
            r = $urandom_range(0, 11);
            sz = 3'($urandom_range(0, 2));
            a = (32'($urandom_range(0, 15)) << 2)
              | (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 32'd1));
            if (r == 0) begin
                idle(1);
            end else if (r == 1) begin
                cycle(1'b1, 2'd1, 1'($urandom_range(0, 1)), a, sz, 32'h0);
            end else begin
                if (r == 2) begin
                    sz = 3'($urandom_range(1, 2));
                    a = a | 32'h1;
                end else if (r == 3) begin
                    sz = 3'd2;
                    a = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
                end else if (r == 4) begin
                    sz = 3'd3;
                    a = a & ~32'h7;
                end
                cycle(1'b1, 2'($urandom_range(2, 3)), 1'($urandom_range(0, 1)),
                      a, sz, $urandom);
            end
        end
        drain();

        mon_en = 1'b0;
        @(negedge clk);
        hsel = 1'b1; htrans = 2'd2; hwrite = 1'b0; haddr = 32'h10; hsize = 3'd2;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'd0;
        #1;
        chk("rd_issue_hold", 32'(hreadyout), 32'(0));
        resetn = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_hreadyout", 32'(hreadyout), 32'(1));
        chk("mid_rst_hresp", 32'(hresp), 32'(0));
        chk("mid_rst_mem", 32'({mem_en, mem_we, mem_addr, mem_be}), 32'(0));
        chk("mid_rst_hrdata", hrdata, 32'h0);
        resetn = 1'b1;
        waits = 0;
        mon_en = 1'b1;
        cycle(1'b1, 2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
        cycle(1'b1, 2'd2, 1'b1, 32'h3C, 3'd1, 32'h5A5A0000);
        cycle(1'b1, 2'd2, 1'b0, 32'h3C, 3'd2, 32'h0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
